// File: rtl/vga_scanout.sv
// VGA raster timing generator and two-stage pixel fetch: S1 issues frame buffer reads,
// S2 drives rgb/hsync/vsync. Define VGA_TEST_PATTERN_EN to add the test_pat colour-bar input.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic               rd_en,
    output logic [9:0]         rd_x,
    output logic [9:0]         rd_y,
    input  logic [COLOR_W-1:0] rd_data,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start,
    output logic               vblank_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic               test_pat
`endif
);

    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic               h_last;
    logic               v_last;
    logic               visible;
    logic               hs_raw;
    logic               vs_raw;
    logic               vis_s1;
    logic               hs_s1;
    logic               vs_s1;
    logic [COLOR_W-1:0] rgb_next;

    assign h_last  = (h_cnt == H_LAST);
    assign v_last  = (v_cnt == V_LAST);
    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));

    // Raster counters: horizontal wraps into a vertical increment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // S1: read request plus the sync/visibility that must travel alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en  <= 1'b0;
            rd_x   <= '0;
            rd_y   <= '0;
            vis_s1 <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
        end else if (pix_en) begin
            rd_en  <= visible;
            vis_s1 <= visible;
            hs_s1  <= hs_raw;
            vs_s1  <= vs_raw;
            if (visible) begin
                rd_x <= h_cnt;
                rd_y <= v_cnt;
            end
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves rgb_next unassigned (no latch).
        rgb_next = '0;
        if (vis_s1) begin
            rgb_next = rd_data;
`ifdef VGA_TEST_PATTERN_EN
            // rd_x still holds the column of the pixel now in S2.
            if (test_pat) rgb_next = COLOR_W'(rd_x[8:6]);
`endif
        end
    end

    // S2: pin stage, aligned with returned frame buffer data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            rgb   <= rgb_next;
            hsync <= hs_s1;
            vsync <= vs_s1;
        end
    end

    // Strobes fire on the wrapping tick and self-clear on the next clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            frame_start  <= pix_en && h_last && v_last;
            vblank_start <= pix_en && h_last && (v_cnt == V_VIS_LAST);
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster (552x10 ticks) so whole frames fit;
// the driver pushes expected outputs per pix_en tick and a monitor pops and compares them.
module tb_vga_scanout;

    localparam int HA = 520, HFP = 8, HS = 16, HBP = 8;
    localparam int VA = 4, VFP = 2, VS = 2, VBP = 2;
    localparam int H_TOTAL     = 552;     // 520+8+16+8
    localparam int V_TOTAL     = 10;      // 4+2+2+2
    localparam int FRAME_TICKS = 5520;    // 552*10
    localparam int FRAME_READS = 2080;    // 520*4
    localparam int VS_LOW      = 1104;    // 2 lines * 552

    typedef struct packed {
        logic       rd_en;
        logic [9:0] rd_x;
        logic [9:0] rd_y;
        logic [2:0] rgb;
        logic       hsync;
        logic       vsync;
        logic       fs;
        logic       vbs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       rd_en;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [2:0] rd_data;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    logic       frame_start;
    logic       vblank_start;
    logic       tp_cur = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_pat = 1'b0;
`endif

    always #5 clk = ~clk;

    // Frame buffer model.
    assign rd_data = 3'((rd_x ^ rd_y) & 10'd7);

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .COLOR_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .rd_en(rd_en),
        .rd_x(rd_x),
        .rd_y(rd_y),
        .rd_data(rd_data),
        .hsync(hsync),
        .vsync(vsync),
        .rgb(rgb),
        .frame_start(frame_start),
        .vblank_start(vblank_start)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .test_pat(test_pat)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        return e;
    endfunction

    function automatic logic [2:0] pix_model(input int h, input int v, input logic tp);
        if (tp) return 3'(h >> 6);
        return 3'((h ^ v) & 7);
    endfunction

    // ---------------- reference model (driver side) ----------------
    int   m_h = 0, m_v = 0, p_h = 0, p_v = 0, m_rdx = 0, m_rdy = 0;
    logic p_valid = 1'b0;

    task automatic model_reset();
        m_h = 0; m_v = 0; m_rdx = 0; m_rdy = 0; p_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_tick();
        exp_t e;
        logic vis;
        e   = reset_exp();
        vis = (m_h < HA) && (m_v < VA);
        if (vis) begin
            m_rdx = m_h;
            m_rdy = m_v;
        end
        e.rd_en = vis;
        e.rd_x  = 10'(m_rdx);
        e.rd_y  = 10'(m_rdy);
        if (p_valid) begin
            e.rgb   = ((p_h < HA) && (p_v < VA)) ? pix_model(p_h, p_v, tp_cur) : 3'd0;
            e.hsync = !((p_h >= HA + HFP) && (p_h < HA + HFP + HS));
            e.vsync = !((p_v >= VA + VFP) && (p_v < VA + VFP + VS));
        end
        e.fs  = (m_h == H_TOTAL - 1) && (m_v == V_TOTAL - 1);
        e.vbs = (m_h == H_TOTAL - 1) && (m_v == VA - 1);
        p_h = m_h; p_v = m_v; p_valid = 1'b1;
        if (m_h == H_TOTAL - 1) begin
            m_h = 0;
            m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic pe);
        @(negedge clk);
        pix_en = pe;
`ifdef VGA_TEST_PATTERN_EN
        test_pat = tp_cur;
`endif
        if (pe && !rst) push_tick();
    endtask

    task automatic slow_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            repeat (3) step(1'b0);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t held;
    int   tick_abs = 0, since_fs = 0, reads = 0, frames = 0;
    int   last_hfall = -1, last_vfall = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    task automatic compare_out(input exp_t e, input string tag);
        check({tag, ".rd_en"}, 32'(rd_en), 32'(e.rd_en));
        check({tag, ".rd_x"}, 32'(rd_x), 32'(e.rd_x));
        check({tag, ".rd_y"}, 32'(rd_y), 32'(e.rd_y));
        check({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
        check({tag, ".hsync"}, 32'(hsync), 32'(e.hsync));
        check({tag, ".vsync"}, 32'(vsync), 32'(e.vsync));
        check({tag, ".frame_start"}, 32'(frame_start), 32'(e.fs));
        check({tag, ".vblank_start"}, 32'(vblank_start), 32'(e.vbs));
    endtask

    initial begin
        held = reset_exp();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                compare_out(reset_exp(), "reset");
                held = reset_exp();
                since_fs = 0; reads = 0; last_hfall = -1; last_vfall = -1;
                prev_hs = 1'b1; prev_vs = 1'b1;
            end else if (pix_en) begin
                if (exp_q.size() == 0) begin
                    check("tick_without_expectation", 32'(exp_q.size()), 32'd1);
                end else begin
                    held = exp_q.pop_front();
                    compare_out(held, "tick");
                    held.fs  = 1'b0;
                    held.vbs = 1'b0;
                end
                tick_abs++;
                since_fs++;
                if (rd_en) reads++;
                if (prev_hs && !hsync) begin
                    if (last_hfall >= 0) check("hsync_period", 32'(tick_abs - last_hfall), 32'(H_TOTAL));
                    last_hfall = tick_abs;
                end
                if (!prev_hs && hsync && last_hfall >= 0)
                    check("hsync_low_ticks", 32'(tick_abs - last_hfall), 32'(HS));
                if (prev_vs && !vsync) begin
                    if (last_vfall >= 0) check("vsync_period", 32'(tick_abs - last_vfall), 32'(FRAME_TICKS));
                    last_vfall = tick_abs;
                end
                if (!prev_vs && vsync && last_vfall >= 0)
                    check("vsync_low_ticks", 32'(tick_abs - last_vfall), 32'(VS_LOW));
                if (frame_start) begin
                    check("frame_ticks", 32'(since_fs), 32'(FRAME_TICKS));
                    check("frame_reads", 32'(reads), 32'(FRAME_READS));
                    since_fs = 0;
                    reads = 0;
                    frames++;
                end
                prev_hs = hsync;
                prev_vs = vsync;
            end else begin
                compare_out(held, "hold");
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with pix_en every 4th clk.
        model_reset();
        rst = 1'b1;
        slow_ticks(3);
        @(negedge clk);
        rst = 1'b0;
        pix_en = 1'b0;

        // Slow run up to (h=300, v=2), then a 3-clk reset that overlaps a pix_en.
        slow_ticks(2 * H_TOTAL + 300);
        @(negedge clk);
        rst = 1'b1;
        pix_en = 1'b1;
        model_reset();
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        rst = 1'b0;
        pix_en = 1'b0;

        // Two full frames at one tick per clk with occasional stalls.
        for (int i = 0; i < 2 * FRAME_TICKS + 10; i++) begin
            step(1'b1);
            if (i % 97 == 50) repeat (5) step(1'b0);
        end

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars across a full line.
        tp_cur = 1'b1;
        for (int i = 0; i < H_TOTAL + 20; i++) step(1'b1);
        tp_cur = 1'b0;
`endif

        repeat (4) step(1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frames_seen", 32'(frames), 32'd2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
